dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store unit directly upstream of the dual-port data memory block; drives its port A (address, data, rden, wren, byteena) and consumes its registered read output.
- Takes one RV32I load/store request at a time from the multicycle core via a valid/ready handshake and produces word address, byte enables and lane-replicated write data.
- Waits the memory read latency, then aligns and sign/zero-extends the returned word.
- Flags misaligned accesses and illegal funct3 encodings without touching memory.

Parameters:
XLEN, 32, data/address width (matches `XLEN)
DMEM_WIDTH, 12, word-address width of memory port (matches `DMEM_WIDTH)
READ_LATENCY, 2, cycles from rden strobe cycle to valid dmem_q (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept (high only in IDLE)
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  XLEN  byte address
req_wdata  in  XLEN  store data (low bits significant)
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  XLEN  aligned/extended load data; 0 for stores and faults
resp_fault  out  1  misaligned or illegal funct3, valid with resp_valid
dmem_addr  out  DMEM_WIDTH  word address = req_addr[DMEM_WIDTH+1:2]
dmem_data  out  XLEN  write data to memory
dmem_rden  out  1  read strobe
dmem_wren  out  1  write strobe
dmem_byteena  out  4  byte lane enables
dmem_q  in  XLEN  memory read data

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0 immediately; req_ready=1 from first clock edge after rst release. Reset mid-operation abandons the request: no resp_valid, no further strobes.
- Accept on rising edge with req_valid && req_ready; latch we, funct3, addr, wdata. Call the accept edge cycle A.
- FSM: IDLE -> (accept, legal and aligned) ACCESS; IDLE -> (accept, fault) RESP; ACCESS -> store: RESP, load: WAIT; WAIT counts READ_LATENCY cycles, captures dmem_q on last, -> RESP; RESP -> IDLE.
- Fault check: illegal funct3 (011, 110, 111, or 100/101 with req_we=1); H/HU with addr[0]=1; W with addr[1:0]!=0. Fault: resp_valid in cycle A+1 with resp_fault=1, resp_rdata=0, no rden/wren ever asserted.
- ACCESS (cycle A+1): dmem_addr/byteena/data registered; exactly one of rden/wren high for exactly this one cycle; all dmem_* outputs 0 in every other state.
- Store byteena: B = 1<<addr[1:0]; H = addr[1] ? 1100 : 0011; W = 1111. Store data: B replicates wdata[7:0] ×4; H replicates wdata[15:0] ×2; W as-is.
- Loads: byteena=1111, data=0.
- Store response: resp_valid in A+2, rdata=0, fault=0.
- Load timing: dmem_q sampled at end of cycle A+1+READ_LATENCY; resp_valid in A+2+READ_LATENCY.
- Load alignment: shift dmem_q right by 8*addr[1:0]. B sign-extends bit 7; BU zero-extends; H sign-extends bit 15; HU zero-extends; W unchanged.
- resp_valid and resp_rdata/resp_fault are registered, high exactly one cycle (RESP), then zeroed.
- req_ready low from A+1 through RESP. Next accept earliest in cycle after RESP. req_valid held during busy is ignored, not queued.
- dmem_addr wraps implicitly: upper req_addr bits above DMEM_WIDTH+1 ignored.

Test Plan:
- Preload word 0x40 = 0x8091A2F3; LW addr 0x100 -> one-cycle rden, dmem_addr=0x040, byteena=1111 in A+1; resp_valid in A+4 with rdata 0x8091A2F3, fault=0.
- LB 0x103 -> 0xFFFFFF80; LBU 0x101 -> 0x000000A2; LH 0x102 -> 0xFFFF8091; LHU 0x100 -> 0x0000A2F3; issue back-to-back with req_valid held high and check req_ready gaps.
- SB 0x102 wdata 0x12345655 -> wren one cycle, byteena 0100, dmem_data 0x55555555, resp in A+2; then LW 0x100 -> 0x8055A2F3.
- SH 0x102 wdata 0x0000BEEF -> byteena 1100, data 0xBEEFBEEF; LW 0x100 -> 0xBEEFA2F3.
- LH 0x101, SW 0x102, funct3=011, SBU (100 with we=1) -> each resp_fault=1 in A+1, rdata=0, rden/wren never high.
- Assert rst during WAIT of an LW -> outputs 0 immediately, no resp_valid; after release req_ready=1 and a fresh LW 0x100 returns 0x8091A2F3.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: RV32I load/store unit driving port A of the dual-port data memory.
// Accepts one request at a time, issues a single-cycle read or write strobe,
// waits out the memory read latency and returns an aligned, extended load
// result. Misaligned accesses and illegal funct3 codes are answered with a
// fault response without touching memory.

module dmem_lsu #(
   parameter int XLEN         = 32,
   parameter int DMEM_WIDTH   = 12,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [XLEN-1:0]       req_addr,
   input  logic [XLEN-1:0]       req_wdata,
   output logic                  resp_valid,
   output logic [XLEN-1:0]       resp_rdata,
   output logic                  resp_fault,
   output logic [DMEM_WIDTH-1:0] dmem_addr,
   output logic [XLEN-1:0]       dmem_data,
   output logic                  dmem_rden,
   output logic                  dmem_wren,
   output logic [3:0]            dmem_byteena,
   input  logic [XLEN-1:0]       dmem_q
);

   // Wait counter only needs to reach READ_LATENCY-1.
   localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(READ_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WAIT   = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t                  state_reg;
   logic                    we_reg;
   logic [2:0]              funct3_reg;
   logic [1:0]              offset_reg;
   logic [CW-1:0]           cnt_reg;

   logic                    accept;
   logic                    fault_next;
   logic [3:0]              byteena_next;
   logic [XLEN-1:0]         store_data_next;
   logic [DMEM_WIDTH-1:0]   word_addr;
   logic [7:0]              lane_data [4];
   logic                    unused_addr_bits;

   assign accept    = req_valid && req_ready;
   assign word_addr = req_addr[DMEM_WIDTH+1:2];

   // Address bits above the memory window simply wrap.
   assign unused_addr_bits = ^req_addr[XLEN-1:DMEM_WIDTH+2];

   // Classify the incoming request: illegal encodings and misalignment.
   always_comb begin
      fault_next = 1'b0;
      case (req_funct3)
         3'b000:  fault_next = 1'b0;
         3'b001:  fault_next = req_addr[0];
         3'b010:  fault_next = |req_addr[1:0];
         3'b100:  fault_next = req_we;
         3'b101:  fault_next = req_we | req_addr[0];
         default: fault_next = 1'b1;
      endcase
   end

   // Byte lane enables: stores select their lanes, loads read the whole word.
   always_comb begin
      byteena_next = 4'b1111;
      if (req_we) begin
         case (req_funct3[1:0])
            2'b00:   byteena_next = 4'b0001 << req_addr[1:0];
            2'b01:   byteena_next = req_addr[1] ? 4'b1100 : 4'b0011;
            default: byteena_next = 4'b1111;
         endcase
      end
   end

   // Store data is replicated across lanes so the byte enables pick the target.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign lane_data[gi] = (req_funct3[1:0] == 2'b00) ? req_wdata[7:0] :
                                (req_funct3[1:0] == 2'b01) ? req_wdata[8*(gi%2) +: 8] :
                                                             req_wdata[8*gi +: 8];
      end
   endgenerate

   assign store_data_next = XLEN'({lane_data[3], lane_data[2], lane_data[1], lane_data[0]});

   // Shift the returned word down to the addressed byte and extend it.
   function automatic logic [XLEN-1:0] align_load(
      input logic [XLEN-1:0] q,
      input logic [2:0]      f3,
      input logic [1:0]      off
   );
      logic [XLEN-1:0] s;
      s = q >> {off, 3'b000};
      case (f3)
         3'b000:  align_load = {{(XLEN-8){s[7]}}, s[7:0]};
         3'b100:  align_load = {{(XLEN-8){1'b0}}, s[7:0]};
         3'b001:  align_load = {{(XLEN-16){s[15]}}, s[15:0]};
         3'b101:  align_load = {{(XLEN-16){1'b0}}, s[15:0]};
         default: align_load = s;
      endcase
   endfunction

   // Control FSM with all outputs registered; strobes and response are one-cycle pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         we_reg       <= 1'b0;
         funct3_reg   <= 3'b000;
         offset_reg   <= 2'b00;
         cnt_reg      <= '0;
         req_ready    <= 1'b0;
         resp_valid   <= 1'b0;
         resp_rdata   <= '0;
         resp_fault   <= 1'b0;
         dmem_addr    <= '0;
         dmem_data    <= '0;
         dmem_rden    <= 1'b0;
         dmem_wren    <= 1'b0;
         dmem_byteena <= 4'b0000;
      end else begin
         resp_valid   <= 1'b0;
         resp_rdata   <= '0;
         resp_fault   <= 1'b0;
         dmem_addr    <= '0;
         dmem_data    <= '0;
         dmem_rden    <= 1'b0;
         dmem_wren    <= 1'b0;
         dmem_byteena <= 4'b0000;

         case (state_reg)
            S_IDLE: begin
               req_ready <= 1'b1;
               if (accept) begin
                  req_ready  <= 1'b0;
                  we_reg     <= req_we;
                  funct3_reg <= req_funct3;
                  offset_reg <= req_addr[1:0];
                  if (fault_next) begin
                     // Faults skip memory entirely and answer next cycle.
                     resp_valid <= 1'b1;
                     resp_fault <= 1'b1;
                     state_reg  <= S_RESP;
                  end else begin
                     dmem_addr    <= word_addr;
                     dmem_byteena <= byteena_next;
                     dmem_data    <= req_we ? store_data_next : '0;
                     dmem_wren    <= req_we;
                     dmem_rden    <= ~req_we;
                     state_reg    <= S_ACCESS;
                  end
               end
            end

            S_ACCESS: begin
               if (we_reg) begin
                  resp_valid <= 1'b1;
                  state_reg  <= S_RESP;
               end else begin
                  cnt_reg   <= '0;
                  state_reg <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (cnt_reg == CNT_LAST) begin
                  resp_valid <= 1'b1;
                  resp_rdata <= align_load(dmem_q, funct3_reg, offset_reg);
                  state_reg  <= S_RESP;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end

            S_RESP: begin
               req_ready <= 1'b1;
               state_reg <= S_IDLE;
            end

            default: begin
               req_ready <= 1'b0;
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: drives dmem_lsu with directed and random requests against a
// byte-addressed memory model, and checks every cycle against a reference
// model computed from the load/store rules.

module tb_dmem_lsu;

   localparam int RL = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [11:0] dmem_addr;
   logic [31:0] dmem_data;
   logic        dmem_rden;
   logic        dmem_wren;
   logic [3:0]  dmem_byteena;
   logic [31:0] dmem_q;

   always #5 clk = ~clk;

   dmem_lsu #(.XLEN(32), .DMEM_WIDTH(12), .READ_LATENCY(RL)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
      .dmem_addr(dmem_addr), .dmem_data(dmem_data), .dmem_rden(dmem_rden),
      .dmem_wren(dmem_wren), .dmem_byteena(dmem_byteena), .dmem_q(dmem_q)
   );

   // ---------------- memory environment (registered read, latency RL) -------------
   logic [31:0] mem [0:4095];
   logic [31:0] qp  [0:RL-1];

   always @(posedge clk) begin
      if (dmem_wren)
         for (int b = 0; b < 4; b++)
            if (dmem_byteena[b]) mem[dmem_addr][8*b +: 8] <= dmem_data[8*b +: 8];
      // Garbage on non-read cycles catches a capture at the wrong cycle.
      qp[0] <= dmem_rden ? mem[dmem_addr] : $urandom();
      for (int i = 1; i < RL; i++) qp[i] <= qp[i-1];
   end
   assign dmem_q = qp[RL-1];

   // ---------------- counters and reference model ----------------
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_count = 0;
   bit armed = 0;

   logic [31:0] ref_mem [0:4095];
   bit          p_active = 0;
   int          p_acc, p_resp;
   bit          p_fault, p_we;
   logic [11:0] p_addr;
   logic [3:0]  p_be;
   logic [31:0] p_data, p_rdata;

   task automatic checkv(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic int size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic bit spec_fault(input bit we, input logic [2:0] f3, input logic [31:0] a);
      if (!(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
      if (we && f3[2]) return 1'b1;
      return (int'(a[1:0]) % size_of(f3)) != 0;
   endfunction

   function automatic logic [31:0] spec_load(input logic [31:0] word, input logic [2:0] f3, input int off);
      longint w, v;
      int sz;
      sz = size_of(f3);
      w  = longint'(word);
      v  = (w >> (8*off)) % (longint'(1) << (8*sz));
      if (!f3[2] && sz < 4 && v >= (longint'(1) << (8*sz-1)))
         v = v - (longint'(1) << (8*sz));
      return 32'(v);
   endfunction

   // ready comes up on the first clock edge after reset release
   always @(posedge clk or posedge rst) begin
      if (rst) armed = 0;
      else     armed = 1;
   end

   // compare every cycle against the model, then register any accepted request
   always @(negedge clk) begin
      logic         exp_ready;
      logic [127:0] exp_resp, exp_mem;
      int           sz, off;
      cyc++;
      if (rst) begin
         checkv("reset_outputs",
                {req_ready, resp_valid, resp_fault, resp_rdata, dmem_rden, dmem_wren,
                 dmem_addr, dmem_byteena, dmem_data}, 128'h0);
         p_active = 0;
      end else begin
         exp_ready = armed && !(p_active && cyc >= p_acc && cyc <= p_resp);
         exp_resp  = (p_active && cyc == p_resp) ? {1'b1, p_fault, p_rdata} : 128'h0;
         exp_mem   = (p_active && !p_fault && cyc == p_acc) ?
                     {!p_we, p_we, p_addr, p_be, p_data} : 128'h0;
         checkv("req_ready", {127'h0, req_ready}, {127'h0, exp_ready});
         checkv("response", {resp_valid, resp_fault, resp_rdata}, exp_resp);
         checkv("dmem_port", {dmem_rden, dmem_wren, dmem_addr, dmem_byteena, dmem_data}, exp_mem);
         if (p_active && cyc >= p_resp) p_active = 0;

         if (req_valid && exp_ready) begin
            p_active = 1;
            p_acc    = cyc + 1;
            p_we     = req_we;
            p_fault  = spec_fault(req_we, req_funct3, req_addr);
            p_resp   = p_fault ? cyc + 1 : (req_we ? cyc + 2 : cyc + 2 + RL);
            p_addr   = req_addr[13:2];
            sz       = size_of(req_funct3);
            off      = int'(req_addr[1:0]);
            p_be     = 4'h0;
            p_data   = 32'h0;
            p_rdata  = 32'h0;
            if (!p_fault && req_we) begin
               for (int l = 0; l < 4; l++) p_data[8*l +: 8] = req_wdata[8*(l % sz) +: 8];
               for (int i = 0; i < sz; i++) begin
                  p_be[off+i] = 1'b1;
                  ref_mem[p_addr][8*(off+i) +: 8] = req_wdata[8*i +: 8];
               end
            end else if (!p_fault) begin
               p_be    = 4'hF;
               p_rdata = spec_load(ref_mem[p_addr], req_funct3, off);
            end
            acc_count++;
            $display("txn %0d cyc %0d: we=%0d f3=%0d addr=%h wdata=%h fault=%0d exp_rdata=%h",
                     acc_count, cyc, req_we, req_funct3, req_addr, req_wdata, p_fault, p_rdata);
         end
      end
   end

   // ---------------- directed helpers ----------------
   // Present a request (valid stays high) and return in cycle A+1, 1ns after the edge.
   task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      int start;
      bit got;
      req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      start = acc_count;
      got   = 0;
      for (int k = 0; k < 50 && !got; k++) begin
         @(posedge clk); #1;
         if (acc_count != start) got = 1;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL accept_timeout: no accept within 50 cycles for addr %h", a);
      end
   endtask

   // Wait for the response; latency counted in cycles after the accept edge.
   task automatic expect_resp(input string name, input logic [31:0] rd, input bit flt, input int lat);
      int          got_lat;
      logic [31:0] got_rd;
      logic        got_flt;
      got_lat = -1; got_rd = 32'h0; got_flt = 1'b0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk); #1;
         if (resp_valid) begin
            got_lat = n; got_rd = resp_rdata; got_flt = resp_fault;
            break;
         end
      end
      checkv({name, "_latency"}, 128'(got_lat), 128'(lat));
      checkv({name, "_rdata"}, 128'(got_rd), 128'(rd));
      checkv({name, "_fault"}, 128'(got_flt), 128'(flt));
      checkv({name, "_ready_low_in_resp"}, 128'(req_ready), 128'h0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem[i]     = $urandom();
         ref_mem[i] = mem[i];
      end
      mem[12'h040]     = 32'h8091A2F3;
      ref_mem[12'h040] = 32'h8091A2F3;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checkv("ready_low_before_edge", 128'(req_ready), 128'h0);
      @(posedge clk); #1;
      checkv("ready_after_reset", 128'(req_ready), 128'h1);

      // word load with port literal checks in A+1
      issue(1'b0, 3'b010, 32'h100, 32'h0);
      checkv("lw_port", {dmem_rden, dmem_wren, dmem_addr, dmem_byteena, dmem_data},
             {1'b1, 1'b0, 12'h040, 4'hF, 32'h0});
      expect_resp("lw", 32'h8091A2F3, 1'b0, 4);

      // sub-word loads back to back, valid held high
      issue(1'b0, 3'b000, 32'h103, 32'h0); expect_resp("lb", 32'hFFFFFF80, 1'b0, 4);
      issue(1'b0, 3'b100, 32'h101, 32'h0); expect_resp("lbu", 32'h000000A2, 1'b0, 4);
      issue(1'b0, 3'b001, 32'h102, 32'h0); expect_resp("lh", 32'hFFFF8091, 1'b0, 4);
      issue(1'b0, 3'b101, 32'h100, 32'h0); expect_resp("lhu", 32'h0000A2F3, 1'b0, 4);

      // byte store
      issue(1'b1, 3'b000, 32'h102, 32'h12345655);
      checkv("sb_port", {dmem_rden, dmem_wren, dmem_addr, dmem_byteena, dmem_data},
             {1'b0, 1'b1, 12'h040, 4'b0100, 32'h55555555});
      expect_resp("sb", 32'h0, 1'b0, 2);
      issue(1'b0, 3'b010, 32'h100, 32'h0); expect_resp("lw_after_sb", 32'h8055A2F3, 1'b0, 4);

      // half store
      issue(1'b1, 3'b001, 32'h102, 32'h0000BEEF);
      checkv("sh_port", {dmem_rden, dmem_wren, dmem_addr, dmem_byteena, dmem_data},
             {1'b0, 1'b1, 12'h040, 4'b1100, 32'hBEEFBEEF});
      expect_resp("sh", 32'h0, 1'b0, 2);
      issue(1'b0, 3'b010, 32'h100, 32'h0); expect_resp("lw_after_sh", 32'hBEEFA2F3, 1'b0, 4);

      // faults: misaligned and illegal encodings
      issue(1'b0, 3'b001, 32'h101, 32'h0);      expect_resp("lh_misaligned", 32'h0, 1'b1, 1);
      issue(1'b1, 3'b010, 32'h102, 32'hFFFFFFFF); expect_resp("sw_misaligned", 32'h0, 1'b1, 1);
      issue(1'b0, 3'b011, 32'h100, 32'h0);      expect_resp("funct3_011", 32'h0, 1'b1, 1);
      issue(1'b1, 3'b100, 32'h100, 32'h000000AA); expect_resp("sbu_illegal", 32'h0, 1'b1, 1);

      // upper address bits wrap onto the same word
      issue(1'b1, 3'b010, 32'hFFFFC100, 32'h8091A2F3); expect_resp("sw_wrap", 32'h0, 1'b0, 2);

      // reset in the middle of a load's wait
      issue(1'b0, 3'b010, 32'h100, 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      checkv("async_reset_clears",
             {req_ready, resp_valid, resp_fault, resp_rdata, dmem_rden, dmem_wren,
              dmem_addr, dmem_byteena, dmem_data}, 128'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         checkv("no_resp_after_reset", 128'(resp_valid), 128'h0);
      end
      checkv("ready_after_midop_reset", 128'(req_ready), 128'h1);
      issue(1'b0, 3'b010, 32'h100, 32'h0); expect_resp("lw_after_reset", 32'h8091A2F3, 1'b0, 4);

      // random traffic checked by the per-cycle model
      for (int it = 0; it < 600; it++) begin
         req_valid  = ($urandom_range(0, 3) != 0);
         req_we     = 1'($urandom_range(0, 1));
         req_funct3 = 3'($urandom_range(0, 7));
         req_addr   = ($urandom() & 32'hFFFF_C000) | (32'h100 + 32'($urandom_range(0, 31)));
         req_wdata  = $urandom();
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
